alu_exec_unit: RTL and testbench

- Execute-stage ALU that consumes the 4-bit alu_control code produced by the ALU control decoder and computes the RV32I integer result.
- Arithmetic and logic ops take one cycle.
- Shifts are iterative, one bit position per cycle, to save area.
- Operand and result transfers use valid/ready handshakes so the surrounding datapath can stall on a shift.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_iter_shifter.sv | 45 ++++
 rtl/alu_exec_unit.sv | 122 ++++++++++++
 tb/tb_alu_exec_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, alu_control op codes and the
// execute-unit state encoding, common to the control decoder and the ALU.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SRL  = 4'd3;
  localparam logic [3:0] ALU_SRA  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_iter_shifter.sv
// Bit-serial shifter: loads a value and a count, then shifts one position
// per cycle until the count runs out; last flags the final shift cycle.
module alu_iter_shifter #(
  parameter int W  = alu_pkg::XLEN,
  parameter int CW = alu_pkg::SHAMT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] amount,
  input  logic [W-1:0]  data_in,
  input  logic          shift_left,
  input  logic          arith,
  output logic [W-1:0]  shifted,
  output logic          last
);

  logic [W-1:0]  work_q;
  logic [CW-1:0] count_q;

  // Right shifts fill with the sign bit only for the arithmetic variant.
  always_comb begin
    if (shift_left) begin
      shifted = {work_q[W-2:0], 1'b0};
    end else begin
      shifted = {arith & work_q[W-1], work_q[W-1:1]};
    end
  end

  assign last = (count_q == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q  <= '0;
      count_q <= '0;
    end else if (load) begin
      work_q  <= data_in;
      count_q <= amount;
    end else if (count_q != '0) begin
      work_q  <= shifted;
      count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// RV32I execute-stage ALU with valid/ready handshakes; single-cycle
// arithmetic/logic ops and iterative one-bit-per-cycle shifts.
module alu_exec_unit #(
  parameter int XLEN    = alu_pkg::XLEN,
  parameter int SHAMT_W = alu_pkg::SHAMT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  import alu_pkg::*;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        op_q;
  logic [XLEN-1:0]   result_q;
  logic              zero_q;
  logic              illegal_q;
  logic [XLEN-1:0]   alu_value;
  logic              code_illegal;
  logic [XLEN-1:0]   shift_value;
  logic              shift_last;
  logic [SHAMT_W-1:0] shamt;
  logic              accept;
  logic              start_shift;

  assign shamt       = op_b[SHAMT_W-1:0];
  assign accept      = in_valid && in_ready;
  assign start_shift = accept && is_shift_op(alu_control) && (shamt != '0);

  // Shift codes pass op_a through here; that is the result when shamt is 0.
  always_comb begin
    alu_value    = '0;
    code_illegal = 1'b0;
    case (alu_control)
      ALU_ADD:  alu_value = op_a + op_b;
      ALU_SUB:  alu_value = op_a - op_b;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  alu_value = op_a;
      ALU_SLT:  alu_value = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_value = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_AND:  alu_value = op_a & op_b;
      ALU_OR:   alu_value = op_a | op_b;
      ALU_XOR:  alu_value = op_a ^ op_b;
      default:  code_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = start_shift ? SHIFT : DONE;
      SHIFT:   if (shift_last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
  end

  // Results are registered so they stay stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= ALU_ADD;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      op_q      <= alu_control;
      illegal_q <= code_illegal;
      if (!start_shift) begin
        result_q <= alu_value;
        zero_q   <= (alu_value == '0);
      end
    end else if ((state_q == SHIFT) && shift_last) begin
      result_q <= shift_value;
      zero_q   <= (shift_value == '0);
    end
  end

  alu_iter_shifter #(
    .W  (XLEN),
    .CW (SHAMT_W)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (start_shift),
    .amount     (shamt),
    .data_in    (op_a),
    .shift_left (op_q == ALU_SLL),
    .arith      (op_q == ALU_SRA),
    .shifted    (shift_value),
    .last       (shift_last)
  );

  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed test-plan cases plus random ops,
// compared every cycle against a cycle-level behavioural model.
module tb_alu_exec_unit;

  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_control = 4'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Returns {illegal, result} straight from the RV32I definitions.
  function automatic logic [32:0] model_alu(input logic [3:0] code,
                                            input logic [31:0] a, input logic [31:0] b);
    int          sh;
    logic [31:0] r;
    logic        ill;
    sh  = int'(b[4:0]);
    r   = 32'd0;
    ill = 1'b0;
    case (code)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a << sh;
      4'd3:    r = a >> sh;
      4'd4:    r = $signed(a) >>> sh;
      4'd5:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    r = (a < b) ? 32'd1 : 32'd0;
      4'd7:    r = a & b;
      4'd8:    r = a | b;
      4'd9:    r = a ^ b;
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  bit          m_known = 1'b0;
  bit          m_done = 1'b0;
  bit          m_postreset = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_res = 32'd0;
  logic        m_zero = 1'b0;
  logic        m_ill = 1'b0;

  // Check what the model expects now, then predict the next rising edge.
  always @(negedge clk) begin : compare
    if (m_known) begin
      checkOutput("in_ready", 32'(in_ready), 32'(!m_done && (m_wait == 0) && !rst));
      checkOutput("out_valid", 32'(out_valid), 32'(m_done));
      if (m_done || m_postreset) begin
        checkOutput("result", result, m_res);
        checkOutput("zero", 32'(zero), 32'(m_zero));
        checkOutput("illegal", 32'(illegal), 32'(m_ill));
      end
    end
    if (rst) begin
      m_known     = 1'b1;
      m_done      = 1'b0;
      m_wait      = 0;
      m_postreset = 1'b1;
      m_res       = 32'd0;
      m_zero      = 1'b0;
      m_ill       = 1'b0;
    end else if (m_known) begin
      if (m_done) begin
        if (out_ready) m_done = 1'b0;
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_done = 1'b1;
      end else if (in_valid) begin
        {m_ill, m_res} = model_alu(alu_control, op_a, op_b);
        m_zero      = (m_res == 32'd0);
        m_postreset = 1'b0;
        if ((alu_control == 4'd2 || alu_control == 4'd3 || alu_control == 4'd4) &&
            (op_b[4:0] != 5'd0)) begin
          m_wait = int'(op_b[4:0]);
        end else begin
          m_done = 1'b1;
        end
      end
    end
  end

  task automatic startOp(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic ready_now, output bit ok);
    int n;
    in_valid    = 1'b1;
    alu_control = code;
    op_a        = a;
    op_b        = b;
    out_ready   = ready_now;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    if (!ok) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      alu_control = 4'($urandom);
      op_a        = $urandom;
      op_b        = $urandom;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                               input int stall, output int lat, output logic [31:0] res,
                               output logic z, output logic il);
    bit ok;
    lat = -1;
    res = 32'hDEAD_BEEF;
    z   = 1'bx;
    il  = 1'bx;
    startOp(code, a, b, (stall == 0), ok);
    if (!ok) return;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      checkOutput("result_timeout", 32'd0, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      return;
    end
    res = result;
    z   = zero;
    il  = illegal;
    // While the result is stalled, upstream presents ops that must be ignored.
    repeat (stall) begin
      @(posedge clk);
      #1;
      in_valid    = 1'b1;
      alu_control = 4'($urandom_range(0, 9));
      op_a        = $urandom;
      op_b        = $urandom;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat;
    logic [31:0] res;
    logic        z;
    logic        il;
    bit          ok;
    logic [3:0]  code;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_zero", 32'(zero), 32'd0);
    checkOutput("reset_illegal", 32'(illegal), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    applyStimulus(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0, lat, res, z, il);
    checkOutput("add_latency", 32'(lat), 32'd1);
    checkOutput("add_result", res, 32'h8000_0000);
    checkOutput("add_zero", 32'(z), 32'd0);

    applyStimulus(ALU_SUB, 32'd5, 32'd5, 0, lat, res, z, il);
    checkOutput("sub_eq_result", res, 32'd0);
    checkOutput("sub_eq_zero", 32'(z), 32'd1);

    applyStimulus(ALU_SUB, 32'd0, 32'd1, 0, lat, res, z, il);
    checkOutput("sub_wrap_result", res, 32'hFFFF_FFFF);

    applyStimulus(ALU_SRA, 32'h8000_0000, 32'd31, 0, lat, res, z, il);
    checkOutput("sra31_latency", 32'(lat), 32'd32);
    checkOutput("sra31_result", res, 32'hFFFF_FFFF);

    applyStimulus(ALU_SLL, 32'd1, 32'h0000_0020, 0, lat, res, z, il);
    checkOutput("sll_shamt0_latency", 32'(lat), 32'd1);
    checkOutput("sll_shamt0_result", res, 32'd1);

    applyStimulus(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 0, lat, res, z, il);
    checkOutput("slt_result", res, 32'd1);
    applyStimulus(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 0, lat, res, z, il);
    checkOutput("sltu_result", res, 32'd0);
    checkOutput("sltu_zero", 32'(z), 32'd1);

    applyStimulus(ALU_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 5, lat, res, z, il);
    checkOutput("xor_result", res, 32'h5A5A_A5A5);

    applyStimulus(4'd12, 32'h1234_5678, 32'h1, 0, lat, res, z, il);
    checkOutput("illegal_flag", 32'(il), 32'd1);
    checkOutput("illegal_result", res, 32'd0);
    checkOutput("illegal_zero", 32'(z), 32'd1);
    checkOutput("illegal_latency", 32'(lat), 32'd1);

    // Reset lands on the tenth cycle of a 20-step SRL.
    startOp(ALU_SRL, 32'hF000_0000, 32'd20, 1'b1, ok);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midshift_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midshift_reset_result", result, 32'd0);
    checkOutput("midshift_reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(ALU_ADD, 32'd2, 32'd3, 0, lat, res, z, il);
    checkOutput("post_reset_add", res, 32'd5);
    checkOutput("post_reset_add_latency", 32'(lat), 32'd1);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) code = 4'($urandom_range(10, 15));
      else code = 4'($urandom_range(0, 9));
      applyStimulus(code, $urandom, $urandom, $urandom_range(0, 3), lat, res, z, il);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
